// File: rtl/fft_pkg.sv
// Shared types and helpers for the sequential DIF FFT memory sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRd,
        StWait,
        StOut
    } fft_state_e;

    // WAIT covers the memory read, the butterfly latency and the registered write request.
    localparam int unsigned WaitExtra = 3;

    function automatic int unsigned wait_cyc(input int unsigned lat);
        return lat + WaitExtra;
    endfunction

    // Reverses the low 'width' bits of v; bits above width are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(width - 1 - i)] = v[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Resettable shift register carrying the read strobe/address to the write-back port.
module fft_delay_line #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_mem_seq_ctrl.sv
// Sequencer for the FFT sample memory: bit-reversed load, in-place DIF stages, natural-order
// output. Stage reads, twiddle index and output reads are registered; write-back is delayed.
module fft_mem_seq_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned SIZE = 4,
    parameter int unsigned LAT  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            in_valid_i,
    output logic            load_data_o,
    output logic [SIZE-1:0] invert_adr_o,
    output logic            en_rd_o,
    output logic [SIZE-1:0] rd_ptr_o,
    output logic [SIZE-2:0] tw_adr_o,
    output logic            en_wr_o,
    output logic [SIZE-1:0] wr_ptr_o,
    output logic            out_valid_o,
    output logic [SIZE-1:0] stage_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned      WaitCyc   = wait_cyc(LAT);
    localparam int unsigned      WaitW     = (WaitCyc > 1) ? $clog2(WaitCyc) : 1;
    localparam logic [SIZE-1:0]  LastAdr   = SIZE'(N - 1);
    localparam logic [SIZE-1:0]  LastStage = SIZE'(SIZE - 1);
    localparam logic [SIZE:0]    OutEnd    = (SIZE+1)'(N);
    localparam logic [WaitW-1:0] WaitLast  = WaitW'(WaitCyc - 1);

    fft_state_e      state_q, state_d;
    logic [SIZE-1:0] load_cnt_q, load_cnt_d;
    logic [SIZE-1:0] rd_cnt_q, rd_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SIZE:0]   out_cnt_q, out_cnt_d;
    logic [SIZE-1:0] stage_q, stage_d;
    logic            en_rd_q, en_rd_d;
    logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [SIZE-2:0] tw_adr_q, tw_adr_d;
    logic            out_valid_q, out_valid_d;

    logic [SIZE-1:0] span;
    logic [SIZE-2:0] mask;
    logic [SIZE-2:0] pair_k;
    logic [SIZE-2:0] pair_j;
    logic [SIZE-1:0] top;

    // Pair k: j = k mod h, top = 2h*(k/h) + j, bottom = top + h, with h = N >> (stage+1).
    always_comb begin
        span   = SIZE'(1) << (LastStage - stage_q);
        mask   = (SIZE-1)'(span - SIZE'(1));
        pair_k = rd_cnt_q[SIZE-1:1];
        pair_j = pair_k & mask;
        top    = {pair_k & ~mask, 1'b0} | {1'b0, pair_j};
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        out_cnt_d   = out_cnt_q;
        stage_d     = stage_q;
        en_rd_d     = 1'b0;
        rd_ptr_d    = '0;
        tw_adr_d    = '0;
        out_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                    stage_d    = '0;
                end
            end
            StLoad: begin
                if (in_valid_i) begin
                    load_cnt_d = load_cnt_q + SIZE'(1);
                    if (load_cnt_q == LastAdr) begin
                        state_d    = StRd;
                        load_cnt_d = '0;
                        stage_d    = '0;
                        rd_cnt_d   = '0;
                    end
                end
            end
            StRd: begin
                en_rd_d  = 1'b1;
                rd_ptr_d = rd_cnt_q[0] ? (top | span) : top;
                tw_adr_d = pair_j << stage_q;
                rd_cnt_d = rd_cnt_q + SIZE'(1);
                if (rd_cnt_q == LastAdr) begin
                    state_d    = StWait;
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
                if (wait_cnt_q == WaitLast) begin
                    wait_cnt_d = '0;
                    if (stage_q == LastStage) begin
                        state_d   = StOut;
                        out_cnt_d = '0;
                    end else begin
                        state_d  = StRd;
                        stage_d  = stage_q + SIZE'(1);
                        rd_cnt_d = '0;
                    end
                end
            end
            StOut: begin
                // out_cnt == N is the extra cycle that raises done after the last read.
                if (out_cnt_q != OutEnd) begin
                    out_valid_d = 1'b1;
                    rd_ptr_d    = out_cnt_q[SIZE-1:0];
                    out_cnt_d   = out_cnt_q + (SIZE+1)'(1);
                end else begin
                    state_d   = StIdle;
                    out_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            load_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            out_cnt_q   <= '0;
            stage_q     <= '0;
            en_rd_q     <= 1'b0;
            rd_ptr_q    <= '0;
            tw_adr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            out_cnt_q   <= out_cnt_d;
            stage_q     <= stage_d;
            en_rd_q     <= en_rd_d;
            rd_ptr_q    <= rd_ptr_d;
            tw_adr_q    <= tw_adr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // One cycle of memory read plus the butterfly latency.
    fft_delay_line #(
        .Width(SIZE + 1),
        .Depth(LAT + 1)
    ) u_wb_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({en_rd_q, rd_ptr_q}),
        .q_o  ({en_wr_o, wr_ptr_o})
    );

    assign load_data_o  = (state_q == StLoad) && in_valid_i;
    assign invert_adr_o = (state_q == StLoad) ? SIZE'(bitrev(32'(load_cnt_q), SIZE)) : '0;
    assign en_rd_o      = en_rd_q;
    assign rd_ptr_o     = rd_ptr_q;
    assign tw_adr_o     = tw_adr_q;
    assign out_valid_o  = out_valid_q;
    assign stage_o      = stage_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StOut) && (out_cnt_q == OutEnd);

endmodule
